uart_tx_fifo: RTL and testbench

Transmit-side buffer placed between the CPU memory bus and the uart block. The CPU writes bytes into a DEPTH-entry FIFO without waiting on the serial line. A drain FSM acts as a bus master on the uart's memory bus port: it polls the uart STATUS register for tx_write_ready, then writes the head byte to the uart DATA register. This removes software busy-waiting on the uart's single-byte transmitter.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart block and the buffers that sit in front of it:
// register offsets, STATUS bit positions and the tx drain-state encoding.
package uart_pkg;

  // Downstream uart register offsets (address bits [3:2])
  localparam logic [1:0] REG_CLK_DIV = 2'b00;
  localparam logic [1:0] REG_STATUS  = 2'b01;
  localparam logic [1:0] REG_DATA    = 2'b10;

  // Tx buffer's own CPU-facing register offsets
  localparam logic [1:0] TXF_REG_DATA   = 2'b00;
  localparam logic [1:0] TXF_REG_STATUS = 2'b01;

  // STATUS bit positions; bit 0 is tx_write_ready on the uart and ~full on the buffer
  localparam int unsigned STAT_TX_READY = 0;
  localparam int unsigned STAT_EMPTY    = 1;
  localparam int unsigned STAT_OVERFLOW = 2;
  localparam int unsigned STAT_INT_EN   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPoll,
    StWrite
  } drain_state_e;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] offset);
    return base + {28'b0, offset, 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count and a combinational head output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit buffer for the uart: queues bytes and drains them by polling the
// uart STATUS register and writing its DATA register as a bus master.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] UART_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] m_address_out,
  output logic        m_sel_out,
  output logic        m_read_out,
  output logic [3:0]  m_write_mask_out,
  output logic [31:0] m_write_value_out,
  input  logic [31:0] m_read_value_in,
  input  logic        m_ready_in,
  output logic        empty_int
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  drain_state_e    state_q, state_d;
  logic            overflow_q, overflow_d;
  logic            int_en_q, int_en_d;
  logic            full, empty;
  logic [CntW-1:0] count;
  logic [8:0]      count_ext;
  logic [7:0]      head;
  logic            push, pop, stat_wr;

  assign push    = sel_in & (address_in[3:2] == TXF_REG_DATA) & write_mask_in[0];
  assign stat_wr = sel_in & (address_in[3:2] == TXF_REG_STATUS) & write_mask_in[0];
  assign pop     = (state_q == StWrite) & m_ready_in;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (write_value_in[7:0]),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .head_o      (head)
  );

  always_comb begin
    overflow_d = overflow_q;
    int_en_d   = int_en_q;
    // A pop in the same cycle frees a slot, so that push is not an overflow
    if (push && full && !pop) overflow_d = 1'b1;
    if (stat_wr) begin
      if (write_value_in[STAT_OVERFLOW]) overflow_d = 1'b0;
      int_en_d = write_value_in[STAT_INT_EN];
    end
  end

  always_comb begin
    state_d           = state_q;
    m_address_out     = '0;
    m_sel_out         = 1'b0;
    m_read_out        = 1'b0;
    m_write_mask_out  = '0;
    m_write_value_out = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StPoll;
      end
      StPoll: begin
        m_sel_out     = 1'b1;
        m_read_out    = 1'b1;
        m_address_out = reg_addr(UART_BASE, REG_STATUS);
        if (m_ready_in && m_read_value_in[STAT_TX_READY]) state_d = StWrite;
      end
      StWrite: begin
        m_sel_out         = 1'b1;
        m_address_out     = reg_addr(UART_BASE, REG_DATA);
        m_write_mask_out  = 4'b0001;
        m_write_value_out = {24'b0, head};
        if (m_ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Bus goes quiet as soon as reset is asserted, not one cycle later
    if (!reset_n) begin
      m_address_out     = '0;
      m_sel_out         = 1'b0;
      m_read_out        = 1'b0;
      m_write_mask_out  = '0;
      m_write_value_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      overflow_q <= 1'b0;
      int_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      int_en_q   <= int_en_d;
    end
  end

  assign count_ext = 9'(count);

  always_comb begin
    read_value_out = '0;
    if (sel_in && (address_in[3:2] == TXF_REG_STATUS)) begin
      read_value_out[15:8]          = count_ext[7:0];
      read_value_out[STAT_INT_EN]   = int_en_q;
      read_value_out[STAT_OVERFLOW] = overflow_q;
      read_value_out[STAT_EMPTY]    = empty;
      read_value_out[STAT_TX_READY] = ~full;
    end
  end

  assign ready_out = sel_in;
  assign empty_int = reset_n & int_en_q & empty & (state_q == StIdle);

  logic unused_ok;
  assign unused_ok = ^{read_in, address_in[31:4], address_in[1:0], write_mask_in[3:1],
                       write_value_in[31:8], m_read_value_in[31:1]};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-level model of the buffer plus a simple
// uart slave with programmable busy time; outputs are compared every cycle.
module tb_uart_tx_fifo;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] m_address_out;
  logic        m_sel_out;
  logic        m_read_out;
  logic [3:0]  m_write_mask_out;
  logic [31:0] m_write_value_out;
  logic [31:0] m_read_value_in;
  logic        m_ready_in;
  logic        empty_int;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .UART_BASE (BASE)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .address_in        (address_in),
    .sel_in            (sel_in),
    .read_in           (read_in),
    .read_value_out    (read_value_out),
    .write_mask_in     (write_mask_in),
    .write_value_in    (write_value_in),
    .ready_out         (ready_out),
    .m_address_out     (m_address_out),
    .m_sel_out         (m_sel_out),
    .m_read_out        (m_read_out),
    .m_write_mask_out  (m_write_mask_out),
    .m_write_value_out (m_write_value_out),
    .m_read_value_in   (m_read_value_in),
    .m_ready_in        (m_ready_in),
    .empty_int         (empty_int)
  );

  // uart slave model
  logic        uart_hold;
  logic        rdy_gate;
  logic [31:0] junk;
  int          busy_cnt;
  int          lat;
  assign m_ready_in      = m_sel_out & rdy_gate;
  assign m_read_value_in = {junk[31:1], (busy_cnt == 0) && !uart_hold};

  // buffer model
  logic [7:0]  q_m[$];
  logic [7:0]  rx[$];
  logic        ovf_m;
  logic        inten_m;
  logic        last_poll_ok;
  logic [31:0] last_rd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    int sz;
    sz = q_m.size();
    return {16'h0, 8'(sz), 4'h0, inten_m, ovf_m, sz == 0, sz != DEPTH};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_msel", 32'(m_sel_out), 32'h0);
      chk("rst_mbus", 32'(|{m_read_out, m_write_mask_out, m_address_out, m_write_value_out}),
          32'h0);
      chk("rst_int", 32'(empty_int), 32'h0);
    end else begin
      chk("rd_value", read_value_out,
          (sel_in && address_in[3:2] == 2'b01) ? status_m() : 32'h0);
      chk("ready", 32'(ready_out), 32'(sel_in));
      chk("empty_int", 32'(empty_int), 32'(inten_m && q_m.size() == 0));
      if (q_m.size() == 0) chk("sel_when_empty", 32'(m_sel_out), 32'h0);
      if (!m_sel_out) begin
        chk("idle_bus", 32'(|{m_read_out, m_write_mask_out, m_address_out, m_write_value_out}),
            32'h0);
      end else if (m_read_out) begin
        chk("poll_addr", m_address_out, BASE + 32'h4);
        chk("poll_mask", 32'(m_write_mask_out), 32'h0);
      end else begin
        chk("wr_addr", m_address_out, BASE + 32'h8);
        chk("wr_mask", 32'(m_write_mask_out), 32'h1);
        if (q_m.size() > 0) chk("wr_head", m_write_value_out, {24'h0, q_m[0]});
      end
    end
  end

  // One clock: predict the edge from pre-edge inputs and bus, then apply after the edge
  task automatic cyc();
    logic       rst, pop, poll, pollv, push, swr, acc;
    logic [7:0] pbyte, wbyte;
    logic [31:0] sval;
    int         sz;
    @(negedge clk);
    #1;
    last_rd = read_value_out;
    rst   = !reset_n;
    pop   = !rst && m_sel_out && !m_read_out && m_ready_in;
    poll  = !rst && m_sel_out && m_read_out && m_ready_in;
    pollv = m_read_value_in[0];
    push  = !rst && sel_in && address_in[3:2] == 2'b00 && write_mask_in[0];
    swr   = !rst && sel_in && address_in[3:2] == 2'b01 && write_mask_in[0];
    pbyte = write_value_in[7:0];
    sval  = write_value_in;
    wbyte = m_write_value_out[7:0];
    sz    = q_m.size();
    acc   = push && (sz < DEPTH || pop);
    if (pop) begin
      chk("pop_nonempty", 32'(sz > 0), 32'h1);
      chk("poll_saw_ready", 32'(last_poll_ok), 32'h1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q_m.delete();
      ovf_m        = 1'b0;
      inten_m      = 1'b0;
      last_poll_ok = 1'b0;
    end else begin
      if (pop) begin
        rx.push_back(wbyte);
        if (sz > 0) void'(q_m.pop_front());
        last_poll_ok = 1'b0;
      end
      if (poll) last_poll_ok = pollv;
      if (acc) q_m.push_back(pbyte);
      else if (push) ovf_m = 1'b1;
      if (swr) begin
        if (sval[2]) ovf_m = 1'b0;
        inten_m = sval[3];
      end
    end
    if (pop) busy_cnt = lat;
    else if (busy_cnt > 0) busy_cnt--;
    rdy_gate = ($urandom_range(0, 3) != 0);
    junk     = $urandom();
  endtask

  task automatic bus_idle(input bit force_sel);
    logic [31:0] a;
    a              = $urandom();
    sel_in         = force_sel ? 1'b1 : ($urandom_range(0, 7) != 0);
    address_in     = {a[31:4], 2'b01, a[1:0]};
    read_in        = 1'b1;
    write_mask_in  = 4'h0;
    write_value_in = $urandom();
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [31:0] val);
    logic [31:0] a;
    logic [3:0]  m;
    a              = $urandom();
    m              = 4'($urandom());
    sel_in         = 1'b1;
    address_in     = {a[31:4], off, a[1:0]};
    read_in        = 1'b0;
    write_mask_in  = {m[3:1], 1'b1};
    write_value_in = val;
    cyc();
    bus_idle(1'b1);
  endtask

  task automatic wr_data(input logic [7:0] b);
    logic [31:0] r;
    r = $urandom();
    wr_reg(2'b00, {r[31:8], b});
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((q_m.size() != 0 || m_sel_out) && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, 32'(n < budget), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r;
    logic found;
    reset_n      = 1'b0;
    uart_hold    = 1'b0;
    rdy_gate     = 1'b1;
    junk         = 32'h0;
    busy_cnt     = 0;
    lat          = 20;
    ovf_m        = 1'b0;
    inten_m      = 1'b0;
    last_poll_ok = 1'b0;
    last_rd      = 32'h0;
    bus_idle(1'b1);
    repeat (3) cyc();
    reset_n = 1'b1;

    // reset state
    bus_idle(1'b1);
    cyc();
    chk("reset_status", last_rd, 32'h0000_0003);
    chk("reset_int", 32'(empty_int), 32'h0);

    // burst of three bytes, uart busy 20 cycles after each
    rx.delete();
    wr_data(8'h41);
    wr_data(8'h42);
    wr_data(8'h43);
    wait_drain("burst_drain", 600);
    chk("burst_len", 32'(rx.size()), 32'd3);
    chk("burst_b0", 32'(rx[0]), 32'h41);
    chk("burst_b1", 32'(rx[1]), 32'h42);
    chk("burst_b2", 32'(rx[2]), 32'h43);
    cyc();
    chk("burst_status", last_rd, 32'h0000_0003);

    // fill past full with the uart held busy
    rx.delete();
    uart_hold = 1'b1;
    for (int i = 0; i < 17; i++) wr_data(8'(8'h60 + i));
    cyc();
    chk("full_status", last_rd, 32'h0000_1004);
    wr_reg(2'b01, 32'h4);
    cyc();
    chk("ovf_cleared", last_rd, 32'h0000_1000);

    // push while full in the same cycle as the WRITE handshake
    uart_hold = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      if (m_sel_out && !m_read_out) begin
        rdy_gate = 1'b1;
        wr_data(8'h77);
        found = 1'b1;
      end else begin
        cyc();
      end
      n++;
    end
    chk("simul_found", 32'(found), 32'h1);
    cyc();
    chk("simul_status", last_rd, 32'h0000_1000);
    wait_drain("simul_drain", 2000);
    chk("simul_len", 32'(rx.size()), 32'd17);
    for (int i = 0; i < 16; i++) chk("simul_byte", 32'(rx[i]), 32'(8'h60 + i));
    chk("simul_last", 32'(rx[16]), 32'h77);

    // stream 40 bytes through, software-style waiting on ~full
    rx.delete();
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(0, 3);
      n = 0;
      do begin
        bus_idle(1'b1);
        cyc();
        n++;
      end while (!last_rd[0] && n < 500);
      chk("wrap_wait", 32'(n < 500), 32'h1);
      wr_data(8'(i));
    end
    wait_drain("wrap_drain", 2000);
    chk("wrap_len", 32'(rx.size()), 32'd40);
    for (int i = 0; i < 40; i++) chk("wrap_byte", 32'(rx[i]), 32'(i));
    cyc();
    chk("wrap_status", last_rd, 32'h0000_0003);

    // empty interrupt
    wr_reg(2'b01, 32'h8);
    cyc();
    chk("inten_status", last_rd, 32'h0000_000b);
    chk("int_on_idle", 32'(empty_int), 32'h1);
    uart_hold = 1'b1;
    wr_data(8'h5a);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("int_while_busy", 32'(empty_int), 32'h0);
    end
    uart_hold = 1'b0;
    wait_drain("int_drain", 500);
    chk("int_after_write", 32'(empty_int), 32'h1);
    chk("int_byte", 32'(rx[rx.size() - 1]), 32'h5a);
    wr_reg(2'b01, 32'h0);
    chk("int_disabled", 32'(empty_int), 32'h0);

    // reset in the middle of a drain with three bytes queued
    uart_hold = 1'b1;
    wr_data(8'h91);
    wr_data(8'h92);
    wr_data(8'h93);
    repeat (3) cyc();
    rx.delete();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    bus_idle(1'b1);
    cyc();
    chk("midrst_status", last_rd, 32'h0000_0003);
    chk("midrst_msel", 32'(m_sel_out), 32'h0);
    uart_hold = 1'b0;
    repeat (30) cyc();
    chk("midrst_no_bytes", 32'(rx.size()), 32'h0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) uart_hold = !uart_hold;
      lat = $urandom_range(0, 6);
      case (r)
        0, 1, 2, 3: wr_data(8'($urandom()));
        4:          wr_reg(2'b01, $urandom());
        5:          wr_reg(2'($urandom_range(2, 3)), $urandom());
        default: begin
          bus_idle(1'b0);
          cyc();
        end
      endcase
    end
    uart_hold = 1'b0;
    bus_idle(1'b1);
    wait_drain("rand_drain", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
